// File: rtl/pipe_hazard_tracker.sv
// ============================================================================
// Module   : pipe_hazard_tracker
// Purpose  : Hazard / forwarding controller for an N-stage in-order pipeline.
//            Optional counters are enabled by defining PIPE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_tracker #(
   parameter int DEPTH   = 5,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   localparam int SW     = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dec_valid_i,
   input  logic [REG_AW-1:0]         dec_rd_i,
   input  logic                      dec_reg_write_i,
   input  logic [SW-1:0]             dec_ready_stage_i,
   input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
   input  logic                      mem_busy_i,
   input  logic                      redirect_i,
   output logic [DEPTH-1:0]          stall_o,
   output logic [DEPTH-1:0]          flush_o,
   output logic [NUM_SRC*SW-1:0]     fwd_sel_o,
   output logic                      retire_o
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0]               perf_retired_o,
   output logic [31:0]               perf_stall_o,
   output logic [31:0]               perf_flush_o
`endif
);

   localparam logic [SW-1:0] c_exec_stage = SW'(2);
   localparam logic [SW-1:0] c_last_stage = SW'(DEPTH-1);

   // Per-stage metadata for EXEC .. WB
   logic [DEPTH-1:2]  r_valid;
   logic [DEPTH-1:2]  r_wr;
   logic [REG_AW-1:0] r_rd  [2:DEPTH-1];
   logic [SW-1:0]     r_rdy [2:DEPTH-1];

   logic [SW-1:0]      w_rdy_clamped;
   logic [SW-1:0]      w_sel  [NUM_SRC];
   logic [NUM_SRC-1:0] w_wait;
   logic               w_data_stall;
   logic               w_redirect_ok;

   assign w_rdy_clamped = ((dec_ready_stage_i < c_exec_stage) ||
                           (dec_ready_stage_i > c_last_stage)) ? c_last_stage
                                                               : dec_ready_stage_i;

   // Scan oldest to youngest so the youngest producer overrides.
   always_comb begin
      for (int j = 0; j < NUM_SRC; j++) begin
         w_sel[j]  = '0;
         w_wait[j] = 1'b0;
         for (int k = DEPTH-1; k > 2; k--) begin
            if (r_valid[k] && r_wr[k] &&
                (r_rd[k] == ex_rs_i[j*REG_AW +: REG_AW]) &&
                (ex_rs_i[j*REG_AW +: REG_AW] != '0)) begin
               w_sel[j]  = SW'(k);
               w_wait[j] = (r_rdy[k] > SW'(k));
            end
         end
      end
   end

   assign w_data_stall  = r_valid[2] && (|w_wait);
   assign w_redirect_ok = redirect_i && !w_data_stall && !mem_busy_i;

   always_comb begin
      stall_o   = '0;
      flush_o   = '0;
      fwd_sel_o = '0;
      retire_o  = 1'b0;
      if (rst) begin
         flush_o = '1;
      end else begin
         for (int j = 0; j < NUM_SRC; j++) begin
            fwd_sel_o[j*SW +: SW] = w_sel[j];
         end
         retire_o = r_valid[DEPTH-1] && !mem_busy_i;
         if (mem_busy_i) begin
            stall_o = '1;
         end else if (w_data_stall) begin
            stall_o[2:0] = 3'b111;
            flush_o[3]   = 1'b1;
         end else if (redirect_i) begin
            flush_o[2:1] = 2'b11;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (!mem_busy_i) begin
         // Stage 3 takes a bubble while EXEC waits on its operand.
         for (int s = 3; s < DEPTH; s++) begin
            r_valid[s] <= (s == 3 && w_data_stall) ? 1'b0 : r_valid[s-1];
            r_wr[s]    <= r_wr[s-1];
            r_rd[s]    <= r_rd[s-1];
            r_rdy[s]   <= r_rdy[s-1];
         end
         if (!w_data_stall) begin
            r_valid[2] <= w_redirect_ok ? 1'b0 : dec_valid_i;
            r_wr[2]    <= dec_reg_write_i;
            r_rd[2]    <= dec_rd_i;
            r_rdy[2]   <= w_rdy_clamped;
         end
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] r_perf_retired;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_retired <= '0;
         r_perf_stall   <= '0;
         r_perf_flush   <= '0;
      end else begin
         if (retire_o && (r_perf_retired != 32'hFFFF_FFFF)) begin
            r_perf_retired <= r_perf_retired + 32'd1;
         end
         if ((w_data_stall || mem_busy_i) && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_redirect_ok && (r_perf_flush != 32'hFFFF_FFFF)) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign perf_retired_o = r_perf_retired;
   assign perf_stall_o   = r_perf_stall;
   assign perf_flush_o   = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_tracker.sv
// ============================================================================
// Module   : tb_pipe_hazard_tracker
// Purpose  : Directed scoreboard bench for pipe_hazard_tracker at DEPTH=5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_tracker;

   localparam int DEPTH   = 5;
   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int SW      = 3;

   logic                      clk;
   logic                      rst;
   logic                      dec_valid_i;
   logic [REG_AW-1:0]         dec_rd_i;
   logic                      dec_reg_write_i;
   logic [SW-1:0]             dec_ready_stage_i;
   logic [NUM_SRC*REG_AW-1:0] ex_rs_i;
   logic                      mem_busy_i;
   logic                      redirect_i;
   logic [DEPTH-1:0]          stall_o;
   logic [DEPTH-1:0]          flush_o;
   logic [NUM_SRC*SW-1:0]     fwd_sel_o;
   logic                      retire_o;
`ifdef PIPE_PERF_EN
   logic [31:0]               perf_retired_o;
   logic [31:0]               perf_stall_o;
   logic [31:0]               perf_flush_o;
`endif

   pipe_hazard_tracker #(.DEPTH(DEPTH), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) dut (
      .clk               (clk),
      .rst               (rst),
      .dec_valid_i       (dec_valid_i),
      .dec_rd_i          (dec_rd_i),
      .dec_reg_write_i   (dec_reg_write_i),
      .dec_ready_stage_i (dec_ready_stage_i),
      .ex_rs_i           (ex_rs_i),
      .mem_busy_i        (mem_busy_i),
      .redirect_i        (redirect_i),
      .stall_o           (stall_o),
      .flush_o           (flush_o),
      .fwd_sel_o         (fwd_sel_o),
      .retire_o          (retire_o)
`ifdef PIPE_PERF_EN
      ,
      .perf_retired_o    (perf_retired_o),
      .perf_stall_o      (perf_stall_o),
      .perf_flush_o      (perf_flush_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [4:0] stall;
      logic [4:0] flush;
      logic [5:0] fwd;
      logic       ret;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are combinational, so each cycle's expectation is compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".stall"},  32'(stall_o),   32'(e.stall));
         check({e.tag, ".flush"},  32'(flush_o),   32'(e.flush));
         check({e.tag, ".fwd"},    32'(fwd_sel_o), 32'(e.fwd));
         check({e.tag, ".retire"}, 32'(retire_o),  32'(e.ret));
      end
   end

   task automatic step(input logic r, input logic dv, input int rd, input logic rw,
                       input int rdy, input int rs0, input int rs1, input logic busy,
                       input logic redir, input string tag, input logic [4:0] es,
                       input logic [4:0] ef, input logic [5:0] efwd, input logic eret);
      exp_t x;
      @(posedge clk);
      #1;
      rst               = r;
      dec_valid_i       = dv;
      dec_rd_i          = REG_AW'(rd);
      dec_reg_write_i   = rw;
      dec_ready_stage_i = SW'(rdy);
      ex_rs_i           = {REG_AW'(rs1), REG_AW'(rs0)};
      mem_busy_i        = busy;
      redirect_i        = redir;
      x.tag = tag; x.stall = es; x.flush = ef; x.fwd = efwd; x.ret = eret;
      sb.push_back(x);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; dec_valid_i = 1'b0; dec_rd_i = '0; dec_reg_write_i = 1'b0;
      dec_ready_stage_i = '0; ex_rs_i = '0; mem_busy_i = 1'b0; redirect_i = 1'b0;
      repeat (2) @(posedge clk);

      //   r  dv rd rw rdy rs0 rs1 busy rdr  tag                  stall     flush     fwd  ret
      step(1, 1, 5, 1, 3,  5,  0,  0,   0,  "reset",             5'b00000, 5'b11111, 0,  0);
      step(0, 1, 5, 1, 3,  0,  0,  0,   0,  "idle_a",            5'b00000, 5'b00000, 0,  0);
      step(0, 1, 6, 1, 3,  0,  0,  0,   0,  "idle_b",            5'b00000, 5'b00000, 0,  0);
      step(0, 1, 7, 1, 4,  5,  0,  0,   0,  "alu_fwd",           5'b00000, 5'b00000, 3,  0);
      step(0, 1, 8, 1, 3,  6,  5,  0,   0,  "two_fwd",           5'b00000, 5'b00000, 35, 1);
      step(0, 1, 9, 1, 3,  0,  7,  0,   0,  "load_use",          5'b00111, 5'b01000, 24, 1);
      step(0, 1, 9, 1, 3,  0,  7,  0,   0,  "load_fwd",          5'b00000, 5'b00000, 32, 1);
      step(0, 1, 0, 1, 3,  0,  0,  0,   1,  "redirect",          5'b00000, 5'b00110, 0,  0);
      step(0, 1, 0, 1, 4,  9,  8,  0,   0,  "post_redir",        5'b00000, 5'b00000, 35, 1);
      step(0, 1, 7, 1, 3,  0,  0,  0,   0,  "drain_a",           5'b00000, 5'b00000, 0,  1);
      step(0, 1, 7, 1, 3,  0,  0,  0,   0,  "x0_nofwd",          5'b00000, 5'b00000, 0,  0);
      step(0, 1, 10, 1, 4, 7,  0,  0,   0,  "youngest_a",        5'b00000, 5'b00000, 3,  1);
      step(0, 1, 11, 1, 3, 7,  7,  0,   0,  "youngest_b",        5'b00000, 5'b00000, 27, 1);
      for (int i = 0; i < 3; i++)
         step(0, 1, 12, 1, 3, 10, 0, 1,  1,  "busy",              5'b11111, 5'b00000, 3,  0);
      step(0, 1, 12, 1, 3, 10, 0,  0,   1,  "stall_over_redir",  5'b00111, 5'b01000, 3,  1);
      step(0, 1, 12, 1, 3, 10, 0,  0,   1,  "redir_after_stall", 5'b00000, 5'b00110, 4,  1);
      step(0, 1, 1, 1, 3,  0,  0,  0,   0,  "fill_a",            5'b00000, 5'b00000, 0,  0);
      step(0, 1, 2, 1, 3,  0,  0,  0,   0,  "fill_b",            5'b00000, 5'b00000, 0,  1);
      step(0, 1, 3, 1, 3,  0,  0,  0,   0,  "fill_c",            5'b00000, 5'b00000, 0,  0);
      step(1, 0, 0, 0, 0,  3,  0,  0,   0,  "reset_mid",         5'b00000, 5'b11111, 0,  0);
      step(0, 0, 0, 0, 0,  3,  2,  0,   0,  "post_reset",        5'b00000, 5'b00000, 0,  0);
`ifdef PIPE_PERF_EN
      @(negedge clk);
      check("perf_ret_clr",   perf_retired_o, 32'd0);
      check("perf_stall_clr", perf_stall_o,   32'd0);
      check("perf_flush_clr", perf_flush_o,   32'd0);
`endif
      for (int i = 0; i < 2; i++)
         step(0, 0, 0, 0, 0, 3,  2,  0,   0,  "post_reset",        5'b00000, 5'b00000, 0,  0);
      step(0, 1, 13, 1, 7, 0,  0,  0,   0,  "clamp_hi",          5'b00000, 5'b00000, 0,  0);
      step(0, 1, 14, 1, 1, 0,  0,  0,   0,  "clamp_lo",          5'b00000, 5'b00000, 0,  0);
      step(0, 0, 0, 0, 0,  13, 0,  0,   0,  "clamp_stall",       5'b00111, 5'b01000, 3,  0);
      step(0, 0, 0, 0, 0,  13, 0,  0,   0,  "clamp_fwd",         5'b00000, 5'b00000, 4,  1);
      step(0, 0, 0, 0, 0,  0,  14, 0,   0,  "exec_empty",        5'b00000, 5'b00000, 24, 0);
      step(0, 1, 20, 0, 3, 0,  0,  0,   0,  "drain_q",           5'b00000, 5'b00000, 0,  1);
      step(0, 0, 0, 0, 0,  0,  0,  0,   0,  "idle_c",            5'b00000, 5'b00000, 0,  0);
      step(0, 0, 0, 0, 0,  20, 0,  0,   0,  "no_write",          5'b00000, 5'b00000, 0,  0);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef PIPE_PERF_EN
      check("perf_ret_end",   perf_retired_o, 32'd2);
      check("perf_stall_end", perf_stall_o,   32'd1);
      check("perf_flush_end", perf_flush_o,   32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
